div_unit: RTL and testbench

Iterative RV32M divider in the EX stage. It executes DIV/DIVU/REM/REMU one quotient bit per cycle and produces `div_done`, which pipe control uses to hold the pipeline while `ex_is_div_inst & ~div_done`. Divide-by-zero and signed overflow are resolved without iteration. Pipe flush aborts any operation in progress.

---
 rtl/div_unit_pkg.sv | 36 +++
 rtl/div_unit.sv | 146 ++++++++++++++
 tb/tb_div_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared constants, state encoding and op decode helpers for div_unit
//
// Contents:
//   DIV_OP_*      2-bit operation codes (low bits of the RV32M funct3)
//   TRUE / FALSE  single-bit constants
//   div_state_e   divider FSM states (IDLE, CALC, DONE)
//   op_is_signed  high for DIV / REM
//   op_is_rem     high for REM / REMU

package div_unit_pkg;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

    // Bit 0 of the op code marks the unsigned variants.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // Bit 1 of the op code selects the remainder over the quotient.
    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   div_start     in   EX holds a divide instruction (held while it stays in EX)
//   div_op        in   DIV_OP_DIV / DIV_OP_DIVU / DIV_OP_REM / DIV_OP_REMU
//   div_dividend  in   rs1 value
//   div_divisor   in   rs2 value
//   ex_stall      in   EX held for another reason; keeps the unit in DONE
//   pipe_flush    in   trap/interrupt flush; aborts to IDLE
//   div_done      out  div_result valid (decoded from the state register)
//   div_result    out  registered quotient or remainder
//   div_busy      out  unit is iterating (state CALC)

module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_start,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] div_dividend,
    input  logic [XLEN-1:0] div_divisor,
    input  logic            ex_stall,
    input  logic            pipe_flush,
    output logic            div_done,
    output logic [XLEN-1:0] div_result,
    output logic            div_busy
);

    localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e        r_state;
    div_state_e        w_next;

    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_dvd;      // dividend bits shift out MSB first; quotient bits shift in
    logic [XLEN-1:0]   r_dvs;      // divisor magnitude
    logic [XLEN-1:0]   r_rem;      // partial remainder, always below r_dvs
    logic [XLEN-1:0]   r_result;
    logic              r_rem_op;
    logic              r_neg_q;
    logic              r_neg_r;

    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_abs;
    logic [XLEN-1:0]   w_b_abs;
    logic              w_div_zero;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic              w_ge;
    logic [XLEN-1:0]   w_rem_nxt;
    logic [XLEN-1:0]   w_quo_nxt;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic              w_last;

    // Operand decode, only consumed in the start cycle.
    assign w_a_neg    = op_is_signed(div_op) & div_dividend[XLEN-1];
    assign w_b_neg    = op_is_signed(div_op) & div_divisor[XLEN-1];
    assign w_a_abs    = w_a_neg ? -div_dividend : div_dividend;
    assign w_b_abs    = w_b_neg ? -div_divisor  : div_divisor;
    assign w_div_zero = (div_divisor == '0);
    assign w_ovf      = op_is_signed(div_op) && (div_dividend == SIGNED_MIN) && (div_divisor == '1);
    assign w_special  = w_div_zero | w_ovf;

    // One restoring step. The shifted value is below 2*divisor, so a
    // non-negative difference always fits back into XLEN bits.
    assign w_shift   = {r_rem, r_dvd[XLEN-1]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_ge      = ~w_diff[XLEN];
    assign w_rem_nxt = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign w_quo_nxt = {r_dvd[XLEN-2:0], w_ge};
    assign w_last    = (r_cnt == CNT_W'(XLEN-1));

    assign w_quo_fix = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign w_rem_fix = r_neg_r ? -w_rem_nxt : w_rem_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (div_start) w_next = w_special ? ST_DONE : ST_CALC;
            ST_CALC: if (w_last)    w_next = ST_DONE;
            ST_DONE: if (!ex_stall) w_next = ST_IDLE;
            default:                w_next = ST_IDLE;
        endcase
        if (pipe_flush) begin
            w_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_result <= '0;
            r_rem_op <= FALSE;
            r_neg_q  <= FALSE;
            r_neg_r  <= FALSE;
        end else if (!pipe_flush) begin
            if (r_state == ST_IDLE && div_start) begin
                r_rem_op <= op_is_rem(div_op);
                r_cnt    <= '0;
                r_dvd    <= w_a_abs;
                r_dvs    <= w_b_abs;
                r_rem    <= '0;
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= w_a_neg;
                if (w_div_zero) begin
                    r_result <= op_is_rem(div_op) ? div_dividend : '1;
                end else if (w_ovf) begin
                    r_result <= op_is_rem(div_op) ? '0 : div_dividend;
                end
            end else if (r_state == ST_CALC) begin
                r_rem <= w_rem_nxt;
                r_dvd <= w_quo_nxt;
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_result <= r_rem_op ? w_rem_fix : w_quo_fix;
                end
            end
        end
    end

    assign div_done   = (r_state == ST_DONE);
    assign div_busy   = (r_state == ST_CALC);
    assign div_result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit with a plain-arithmetic reference model

module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        div_start;
    logic [1:0]  div_op;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        ex_stall;
    logic        pipe_flush;
    logic        div_done;
    logic [31:0] div_result;
    logic        div_busy;

    div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .div_start    (div_start),
        .div_op       (div_op),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .ex_stall     (ex_stall),
        .pipe_flush   (pipe_flush),
        .div_done     (div_done),
        .div_result   (div_result),
        .div_busy     (div_busy)
    );

    typedef struct {
        logic [31:0] res;
        int          done_cyc;
        int          len;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RISC-V division semantics with wide integers; ops: 0 DIV, 1 DIVU, 2 REM, 3 REMU.
    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (op[0]) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        q = sa / sb;
        r = sa % sb;
        return op[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Monitor: pops one expectation per done pulse, checks value, timing,
    // stability while held and the pulse length.
    logic        in_pulse = 1'b0;
    logic        have_exp = 1'b0;
    logic [31:0] held;
    int          hold_n;
    int          exp_len;
    exp_t        e;

    always @(negedge clk) begin
        if (rst) begin
            in_pulse = 1'b0;
            have_exp = 1'b0;
        end else if (div_done) begin
            if (!in_pulse) begin
                in_pulse = 1'b1;
                held     = div_result;
                hold_n   = 1;
                if (sb_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: cycle %0d result %h, none expected", cyc, div_result);
                    have_exp = 1'b0;
                end else begin
                    e = sb_q.pop_front();
                    have_exp = 1'b1;
                    exp_len  = e.len;
                    total++;
                    if (div_result !== e.res) begin
                        bad++;
                        $display("FAIL %s result: got %h want %h", e.name, div_result, e.res);
                    end
                    total++;
                    if (cyc != e.done_cyc) begin
                        bad++;
                        $display("FAIL %s done_cycle: got %0d want %0d", e.name, cyc, e.done_cyc);
                    end
                end
            end else begin
                hold_n++;
                total++;
                if (div_result !== held) begin
                    bad++;
                    $display("FAIL result_stable: got %h want %h", div_result, held);
                end
            end
        end else if (in_pulse) begin
            in_pulse = 1'b0;
            if (have_exp) begin
                total++;
                if (hold_n != exp_len) begin
                    bad++;
                    $display("FAIL %s done_len: got %0d want %0d", e.name, hold_n, exp_len);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Called at posedge+1 of the intended start cycle; returns at posedge+1
    // of the cycle after the last done cycle with div_start low.
    task automatic do_div(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int stall);
        exp_t x;
        bit   got;
        div_start    = 1'b1;
        div_op       = op;
        div_dividend = a;
        div_divisor  = b;
        x.res      = ref_res(op, a, b);
        x.done_cyc = cyc + ref_lat(op, a, b);
        x.len      = stall + 1;
        x.name     = nm;
        sb_q.push_back(x);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (div_done) begin
                got = 1'b1;
                break;
            end
            div_dividend = $urandom;
            div_divisor  = $urandom;
            div_op       = 2'($urandom_range(0, 3));
            ex_stall     = 1'($urandom_range(0, 1));
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL %s timeout: got no done want done within 100 cycles", nm);
        end
        ex_stall = (stall > 0);
        repeat (stall) begin
            @(posedge clk); #1;
        end
        ex_stall = 1'b0;
        @(posedge clk); #1;
        div_start = 1'b0;
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        int          sel;

        rst = 1'b1; div_start = 1'b0; div_op = 2'd0;
        div_dividend = 32'd0; div_divisor = 32'd0;
        ex_stall = 1'b0; pipe_flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_done",   {31'd0, div_done}, 32'd0);
        check("reset_busy",   {31'd0, div_busy}, 32'd0);
        check("reset_result", div_result,        32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_div("divu_100_7",   2'd1, 32'd100,         32'd7,           0);
        do_div("remu_100_7",   2'd3, 32'd100,         32'd7,           0);
        do_div("div_m7_2",     2'd0, 32'hFFFF_FFF9,   32'd2,           0);
        do_div("rem_m7_2",     2'd2, 32'hFFFF_FFF9,   32'd2,           0);
        do_div("divu_5_0",     2'd1, 32'd5,           32'd0,           0);
        do_div("remu_5_0",     2'd3, 32'd5,           32'd0,           0);
        do_div("div_ovf",      2'd0, 32'h8000_0000,   32'hFFFF_FFFF,   0);
        do_div("rem_ovf",      2'd2, 32'h8000_0000,   32'hFFFF_FFFF,   0);

        // Flush in CALC cycle 10, then a divide starting the very next cycle.
        div_start = 1'b1; div_op = 2'd1; div_dividend = 32'd12345; div_divisor = 32'd77;
        repeat (10) begin
            @(posedge clk); #1;
        end
        pipe_flush = 1'b1;
        @(posedge clk); #1;
        pipe_flush = 1'b0;
        check("flush_busy", {31'd0, div_busy}, 32'd0);
        check("flush_done", {31'd0, div_done}, 32'd0);
        do_div("flush_follow", 2'd1, 32'd1000, 32'd10, 0);

        // DONE held by ex_stall, then a back-to-back divide.
        do_div("stall_div",   2'd0, 32'hFFFF_FF9C, 32'd7, 3);
        do_div("b2b_divu",    2'd1, 32'd9,         32'd3, 0);
        do_div("stall_rem0",  2'd2, 32'd17,        32'd0, 2);

        // Reset in the middle of a divide.
        div_start = 1'b1; div_op = 2'd1; div_dividend = 32'd999; div_divisor = 32'd4;
        repeat (5) begin
            @(posedge clk); #1;
        end
        div_start = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_busy",   {31'd0, div_busy}, 32'd0);
        check("midrst_done",   {31'd0, div_done}, 32'd0);
        check("midrst_result", div_result,        32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int n = 0; n < 24; n++) begin
            op  = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 9);
            a   = $urandom;
            b   = $urandom >> $urandom_range(0, 31);
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) b = $urandom_range(1, 15);
            if (sel == 3) b = -($urandom_range(1, 15));
            do_div($sformatf("rand%0d", n), op, a, b, $urandom_range(0, 2));
        end

        repeat (4) @(posedge clk);
        #1;
        check("queue_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
